// File: rtl/spi_peripheral_if.sv
// spi_peripheral_if: SPI pins, register outputs and write strobe of spi_peripheral
// master: drives sclk/copi/ncs and observes the registers; slave: the register bank
interface spi_peripheral_if;
   logic       sclk;
   logic       copi;
   logic       ncs;
   logic [7:0] reg_en_out;
   logic [7:0] reg_en_pwm_out;
   logic [7:0] reg_out_3_0_pwm_gen_channel;
   logic [7:0] reg_out_7_4_pwm_gen_channel;
   logic [7:0] reg_pwm_gen_0_ch_0_duty_cycle;
   logic [7:0] reg_pwm_gen_0_ch_1_duty_cycle;
   logic [7:0] reg_pwm_gen_1_ch_0_duty_cycle;
   logic [7:0] reg_pwm_gen_1_ch_1_duty_cycle;
   logic [7:0] reg_pwm_gen_1_0_frequency_divider;
   logic       wr_strobe;
   modport master (
      output sclk, copi, ncs,
      input  reg_en_out, reg_en_pwm_out, reg_out_3_0_pwm_gen_channel,
             reg_out_7_4_pwm_gen_channel, reg_pwm_gen_0_ch_0_duty_cycle,
             reg_pwm_gen_0_ch_1_duty_cycle, reg_pwm_gen_1_ch_0_duty_cycle,
             reg_pwm_gen_1_ch_1_duty_cycle, reg_pwm_gen_1_0_frequency_divider,
             wr_strobe
   );
   modport slave (
      input  sclk, copi, ncs,
      output reg_en_out, reg_en_pwm_out, reg_out_3_0_pwm_gen_channel,
             reg_out_7_4_pwm_gen_channel, reg_pwm_gen_0_ch_0_duty_cycle,
             reg_pwm_gen_0_ch_1_duty_cycle, reg_pwm_gen_1_ch_0_duty_cycle,
             reg_pwm_gen_1_ch_1_duty_cycle, reg_pwm_gen_1_0_frequency_divider,
             wr_strobe
   );
endinterface

// File: rtl/spi_peripheral.sv
// spi_peripheral: write-only SPI-slave bank of nine 8-bit PWM control registers
// clk/rst: system clock, async active-high reset
// bus (slave): sclk/copi/ncs in (async to clk), nine register outputs, wr_strobe out
module spi_peripheral #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_REGS    = 9
) (
   input  logic            clk,
   input  logic            rst,
   spi_peripheral_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   state_t                 r_state, w_next;
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
   logic                   r_sclk_hist, r_ncs_hist;
   logic [15:0]            r_shift;
   logic [4:0]             r_count;
   logic [7:0]             r_regs [9];
   logic                   r_strobe;
   logic                   w_sclk_rise, w_ncs_fall, w_ncs_rise, w_copi, w_write;
   logic [6:0]             w_addr;
   assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_hist;
   assign w_ncs_fall  = ~r_ncs_sync[SYNC_STAGES-1] & r_ncs_hist;
   assign w_ncs_rise  = r_ncs_sync[SYNC_STAGES-1] & ~r_ncs_hist;
   assign w_copi      = r_copi_sync[SYNC_STAGES-1];
   assign w_addr      = r_shift[14:8];
   // Only an exact 16-bit write frame to an implemented address commits
   assign w_write     = (r_state == COMMIT) && (r_count == 5'd16) && r_shift[15] &&
                        (int'(w_addr) < NUM_REGS) && (w_addr < 7'd9);
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE && w_ncs_fall)  ? SHIFT  :
               (r_state == SHIFT && w_ncs_rise) ? COMMIT :
               (r_state == COMMIT)              ? IDLE   : r_state;
   end
   // ncs resets high so reset release never fakes a frame start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_copi_sync <= '0;
         r_ncs_sync  <= '1;
         r_sclk_hist <= 1'b0;
         r_ncs_hist  <= 1'b1;
         r_state     <= IDLE;
         r_shift     <= '0;
         r_count     <= '0;
         r_strobe    <= 1'b0;
         for (int i = 0; i < 9; i++) r_regs[i] <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], bus.copi};
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], bus.ncs};
         r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
         r_ncs_hist  <= r_ncs_sync[SYNC_STAGES-1];
         r_state     <= w_next;
         r_strobe    <= w_write;
         if (r_state == IDLE && w_ncs_fall) begin
            r_shift <= '0;
            r_count <= '0;
         end
         // ncs rise wins over a coincident sclk rise; count saturates at 17 to flag overlong frames
         if (r_state == SHIFT && w_sclk_rise && !w_ncs_rise) begin
            r_shift <= {r_shift[14:0], w_copi};
            r_count <= (r_count == 5'd17) ? r_count : r_count + 5'd1;
         end
         if (w_write) r_regs[w_addr[3:0]] <= r_shift[7:0];
      end
   end
   assign bus.reg_en_out                        = r_regs[0];
   assign bus.reg_en_pwm_out                    = r_regs[1];
   assign bus.reg_out_3_0_pwm_gen_channel       = r_regs[2];
   assign bus.reg_out_7_4_pwm_gen_channel       = r_regs[3];
   assign bus.reg_pwm_gen_0_ch_0_duty_cycle     = r_regs[4];
   assign bus.reg_pwm_gen_0_ch_1_duty_cycle     = r_regs[5];
   assign bus.reg_pwm_gen_1_ch_0_duty_cycle     = r_regs[6];
   assign bus.reg_pwm_gen_1_ch_1_duty_cycle     = r_regs[7];
   assign bus.reg_pwm_gen_1_0_frequency_divider = r_regs[8];
   assign bus.wr_strobe                         = r_strobe;
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed SPI frames against hand-computed register contents
module tb_spi_peripheral;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] exp_regs [9];
   int         n_checks = 0;
   int         n_errors = 0;
   int         n_strobes = 0;
   int         exp_strobes = 0;
   spi_peripheral_if bus ();
   spi_peripheral #(.SYNC_STAGES(2), .NUM_REGS(9)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk) if (!rst && bus.wr_strobe) n_strobes++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] rd(input int i);
      case (i)
         0: rd = bus.reg_en_out;
         1: rd = bus.reg_en_pwm_out;
         2: rd = bus.reg_out_3_0_pwm_gen_channel;
         3: rd = bus.reg_out_7_4_pwm_gen_channel;
         4: rd = bus.reg_pwm_gen_0_ch_0_duty_cycle;
         5: rd = bus.reg_pwm_gen_0_ch_1_duty_cycle;
         6: rd = bus.reg_pwm_gen_1_ch_0_duty_cycle;
         7: rd = bus.reg_pwm_gen_1_ch_1_duty_cycle;
         default: rd = bus.reg_pwm_gen_1_0_frequency_divider;
      endcase
   endfunction
   task automatic check_all(input string tag);
      for (int i = 0; i < 9; i++) chk($sformatf("%s_reg%0d", tag, i), 32'(rd(i)), 32'(exp_regs[i]));
      chk({tag, "_strobes"}, n_strobes, exp_strobes);
   endtask
   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic bit_out(input logic b);
      bus.copi = b;
      clks(4);
      bus.sclk = 1'b1;
      clks(4);
      bus.sclk = 1'b0;
   endtask
   // Send the low n bits of v MSB first; optionally leave ncs low for manual timing
   task automatic send(input logic [31:0] v, input int n, input bit raise);
      bus.ncs = 1'b0;
      clks(4);
      for (int i = n - 1; i >= 0; i--) bit_out(v[i]);
      clks(2);
      if (raise) begin
         bus.ncs = 1'b1;
         clks(4);
      end
   endtask
   initial begin
      bus.sclk = 1'b0;
      bus.copi = 1'b0;
      bus.ncs  = 1'b1;
      for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
      clks(3);
      check_all("reset");
      rst = 1'b0;
      clks(4);
      bus.ncs = 1'b0;
      clks(4);
      for (int i = 15; i >= 9; i--) bit_out(i == 15);
      rst = 1'b1;
      bus.ncs = 1'b1;
      clks(4);
      rst = 1'b0;
      clks(4);
      send(32'h8133, 16, 1'b1);
      clks(4);
      exp_regs[1] = 8'h33;
      exp_strobes = 1;
      check_all("midreset");
      send(32'h8455, 16, 1'b0);
      bus.ncs = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("lat_before_reg", 32'(bus.reg_pwm_gen_0_ch_0_duty_cycle), 32'h00);
      chk("lat_before_stb", 32'(bus.wr_strobe), 32'h0);
      @(posedge clk);
      #1;
      chk("lat_at_reg", 32'(bus.reg_pwm_gen_0_ch_0_duty_cycle), 32'h55);
      chk("lat_at_stb", 32'(bus.wr_strobe), 32'h1);
      @(posedge clk);
      #1;
      chk("lat_after_stb", 32'(bus.wr_strobe), 32'h0);
      clks(6);
      exp_regs[4] = 8'h55;
      exp_strobes = 2;
      check_all("w8455");
      for (int a = 0; a < 9; a++) begin
         send({16'h0, 1'b1, 7'(a), 8'(a) ^ 8'hA5}, 16, 1'b1);
         exp_regs[a] = 8'(a) ^ 8'hA5;
      end
      clks(6);
      exp_strobes = 11;
      check_all("allregs");
      send(32'h04FF, 16, 1'b1);
      send(32'h89FF, 16, 1'b1);
      clks(6);
      check_all("rd_oor");
      send(32'h40CC, 15, 1'b1);
      send(32'h180CC, 17, 1'b1);
      clks(6);
      check_all("short_long");
      send(32'h80F0, 16, 1'b1);
      clks(6);
      exp_regs[0] = 8'hF0;
      exp_strobes = 12;
      check_all("w80f0");
      for (int i = 0; i < 5; i++) bit_out(1'b1);
      clks(6);
      check_all("idle_sclk");
      send(32'h8812, 16, 1'b1);
      clks(6);
      exp_regs[8] = 8'h12;
      exp_strobes = 13;
      check_all("w8812");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
